// File: rtl/sys_bus_pkg.sv
// Shared types and constants for the sys-bus arbiter slice.
package sys_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } bus_state_e;

  localparam int unsigned TMO_DEFAULT = 255;

  // Width of a requester index for 2..4 requesters.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: search starts one past the last granted requester.
module rr_arbiter
  import sys_bus_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   last_grant_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   grant_idx_o
);

  int unsigned cand;
  logic        found;

  // NOTE: combinational blocks assign every output a default first and use
  // blocking assignments, so no path can leave a value held (no latch).
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(last_grant_i) + i) % NREQ;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/sys_bus_arbiter.sv
// Shares one sys-bus target between NREQ requesters: round-robin grant,
// single-cycle strobe, response/timeout wait, per-requester ack/err pulses.
module sys_bus_arbiter
  import sys_bus_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 64,
  parameter int unsigned SW   = 8,
  parameter int unsigned TMO  = TMO_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ*AW-1:0] m_addr_i,
  input  logic [NREQ*DW-1:0] m_wdata_i,
  input  logic [NREQ*SW-1:0] m_sel_i,
  input  logic [NREQ-1:0]   m_wen_i,
  input  logic [NREQ-1:0]   m_ren_i,
  output logic [DW-1:0]     m_rdata_o,
  output logic [NREQ-1:0]   m_ack_o,
  output logic [NREQ-1:0]   m_err_o,
  output logic [AW-1:0]     s_addr_o,
  output logic [DW-1:0]     s_wdata_o,
  output logic [SW-1:0]     s_sel_o,
  output logic              s_wen_o,
  output logic              s_ren_o,
  input  logic [DW-1:0]     s_rdata_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  output logic              busy_o
);

  localparam int unsigned IW       = idx_w(NREQ);
  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  bus_state_e      state_q, state_d;
  logic [IW-1:0]   last_q, last_d, gnt_q, gnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            wen_q, wen_d, ren_q, ren_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d, err_q, err_d;

  logic [NREQ-1:0] req_vec, gnt_oh;
  logic [IW-1:0]   gnt_idx;

  assign req_vec = m_wen_i | m_ren_i;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req_i        (req_vec),
    .last_grant_i (last_q),
    .grant_o      (gnt_oh),
    .grant_idx_o  (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    err_d   = '0;
    unique case (state_q)
      // Hold off arbitration while a completion pulse is out: the finished
      // requester still shows its request level in that cycle.
      ST_IDLE: begin
        if (|req_vec && !(|ack_q) && !(|err_q)) begin
          state_d = ST_ISSUE;
          last_d  = gnt_idx;
          gnt_d   = gnt_idx;
          for (int k = 0; k < NREQ; k++) begin
            if (gnt_oh[k]) begin
              addr_d  = m_addr_i[k*AW +: AW];
              wdata_d = m_wdata_i[k*DW +: DW];
              sel_d   = m_sel_i[k*SW +: SW];
              wen_d   = m_wen_i[k];
              ren_d   = m_ren_i[k];
            end
          end
        end
      end
      ST_ISSUE: begin
        if (wen_q && ren_q) begin
          err_d[gnt_q] = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (s_err_i) begin
          err_d[gnt_q] = 1'b1;
          state_d      = ST_IDLE;
        end else if (s_ack_i) begin
          ack_d[gnt_q] = 1'b1;
          if (ren_q) rdata_d = s_rdata_i;
          state_d      = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          err_d[gnt_q] = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value; reset is synchronous to clk, active-low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      last_q  <= IW'(NREQ - 1);
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // An illegal read+write request reaches ISSUE but never strobes the target.
  assign s_wen_o   = (state_q == ST_ISSUE) && wen_q && !ren_q;
  assign s_ren_o   = (state_q == ST_ISSUE) && ren_q && !wen_q;
  assign s_addr_o  = addr_q;
  assign s_wdata_o = wdata_q;
  assign s_sel_o   = sel_q;
  assign m_ack_o   = ack_q;
  assign m_err_o   = err_q;
  assign m_rdata_o = rdata_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Directed bench for sys_bus_arbiter: a small target memory model answers
// strobes one cycle later; completions are checked against a scoreboard.
module tb_sys_bus_arbiter;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [63:0]   m_addr_i;
  logic [127:0]  m_wdata_i;
  logic [15:0]   m_sel_i;
  logic [1:0]    m_wen_i, m_ren_i;
  logic [63:0]   m_rdata_o;
  logic [1:0]    m_ack_o, m_err_o;
  logic [31:0]   s_addr_o;
  logic [63:0]   s_wdata_o;
  logic [7:0]    s_sel_o;
  logic          s_wen_o, s_ren_o;
  logic [63:0]   s_rdata_i;
  logic          s_ack_i, s_err_i;
  logic          busy_o;

  logic          no_ack;
  logic [63:0]   mem [16];

  typedef struct {
    int unsigned idx;
    bit          err;
    bit          rd;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   strb = 0;
  int   last_ack_cyc = 0;
  int   ack_gap = 0;
  int   s0;

  sys_bus_arbiter #(.NREQ(2), .AW(32), .DW(64), .SW(8), .TMO(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .m_addr_i  (m_addr_i),
    .m_wdata_i (m_wdata_i),
    .m_sel_i   (m_sel_i),
    .m_wen_i   (m_wen_i),
    .m_ren_i   (m_ren_i),
    .m_rdata_o (m_rdata_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .s_addr_o  (s_addr_o),
    .s_wdata_o (s_wdata_o),
    .s_sel_o   (s_sel_o),
    .s_wen_o   (s_wen_o),
    .s_ren_o   (s_ren_o),
    .s_rdata_i (s_rdata_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  // Target: registered response one cycle after a strobe, byte-masked writes.
  always @(posedge clk) begin
    if (!rstn) begin
      s_ack_i   <= 1'b0;
      s_err_i   <= 1'b0;
      s_rdata_i <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[1] <= 64'hDEADBEEF12345678;
      mem[2] <= 64'hAABBCCDDEEFF0011;
    end else begin
      s_ack_i <= 1'b0;
      s_err_i <= 1'b0;
      if ((s_wen_o || s_ren_o) && !no_ack) begin
        s_ack_i <= 1'b1;
        if (s_ren_o) s_rdata_i <= mem[s_addr_o[15:12]];
        if (s_wen_o)
          for (int b = 0; b < 8; b++)
            if (s_sel_o[b]) mem[s_addr_o[15:12]][8*b +: 8] <= s_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int unsigned idx, input bit err, input bit rd, input logic [63:0] data);
    exp_t e;
    e.idx = idx; e.err = err; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  task automatic drive_req(input int k, input bit wr, input bit rd, input logic [31:0] a,
                           input logic [63:0] d, input logic [7:0] s);
    m_addr_i[k*32 +: 32]  = a;
    m_wdata_i[k*64 +: 64] = d;
    m_sel_i[k*8 +: 8]     = s;
    m_wen_i[k]            = wr;
    m_ren_i[k]            = rd;
  endtask

  // One cycle: sample at the falling edge, score any completion, and let the
  // completed requester drop its request.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (s_wen_o || s_ren_o) strb++;
    for (int k = 0; k < 2; k++) begin
      if (m_ack_o[k] || m_err_o[k]) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_resp", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("grant_idx", 64'(k), 64'(e.idx));
          check("err_flag", 64'(m_err_o[k]), 64'(e.err));
          if (e.rd && !e.err) check("rdata", m_rdata_o, e.data);
        end
        ack_gap      = cyc - last_ack_cyc;
        last_ack_cyc = cyc;
        m_wen_i[k]   = 1'b0;
        m_ren_i[k]   = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy_o || (|m_wen_i) || (|m_ren_i)) && n < budget) begin
      tick();
      n++;
    end
    check("drain_in_budget", 64'(n < budget), 64'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    no_ack    = 1'b0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    m_sel_i   = '0;
    m_wen_i   = '0;
    m_ren_i   = '0;
    rstn      = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ack", 64'(m_ack_o), 64'd0);
    check("rst_err", 64'(m_err_o), 64'd0);
    check("rst_strobes", 64'({s_wen_o, s_ren_o}), 64'd0);
    check("rst_addr", 64'(s_addr_o), 64'd0);
    check("rst_rdata", m_rdata_o, 64'd0);
    rstn = 1'b1;
    tick();

    // Contention: both requesters every round, grants must alternate 0,1.
    for (int r = 0; r < 4; r++) begin
      drive_req(0, 1'b0, 1'b1, 32'h1000, 64'd0, 8'hFF);
      drive_req(1, 1'b0, 1'b1, 32'h1000, 64'd0, 8'hFF);
      push(0, 1'b0, 1'b1, 64'hDEADBEEF12345678);
      push(1, 1'b0, 1'b1, 64'hDEADBEEF12345678);
      wait_idle(60);
      check("b2b_ack_gap", 64'(ack_gap), 64'd4);
    end

    // Single read with latency checks.
    s0 = strb;
    drive_req(0, 1'b0, 1'b1, 32'h1000, 64'd0, 8'hFF);
    push(0, 1'b0, 1'b1, 64'hDEADBEEF12345678);
    tick();
    check("rd_strobe_t1", 64'(s_ren_o), 64'd1);
    check("rd_addr_t1", 64'(s_addr_o), 64'h1000);
    check("rd_busy_t1", 64'(busy_o), 64'd1);
    tick();
    check("rd_strobe_t2", 64'(s_ren_o), 64'd0);
    check("rd_addr_hold", 64'(s_addr_o), 64'h1000);
    check("rd_noack_t2", 64'(m_ack_o), 64'd0);
    tick();
    check("rd_ack_t3", 64'(m_ack_o), 64'd1);
    tick();
    check("rd_ack_pulse", 64'(m_ack_o), 64'd0);
    check("rd_rdata_hold", m_rdata_o, 64'hDEADBEEF12345678);
    check("rd_one_strobe", 64'(strb - s0), 64'd1);

    // Partial write then read-back.
    drive_req(0, 1'b1, 1'b0, 32'h2000, 64'h1122334455667788, 8'h0F);
    push(0, 1'b0, 1'b0, 64'd0);
    wait_idle(30);
    drive_req(0, 1'b0, 1'b1, 32'h2000, 64'd0, 8'hFF);
    push(0, 1'b0, 1'b1, 64'hAABBCCDD55667788);
    wait_idle(30);

    // Timeout with a silent target.
    no_ack = 1'b1;
    drive_req(0, 1'b0, 1'b1, 32'h1000, 64'd0, 8'hFF);
    push(0, 1'b1, 1'b1, 64'd0);
    tick();
    tick();
    repeat (7) tick();
    check("tmo_noerr_early", 64'(m_err_o), 64'd0);
    check("tmo_busy_early", 64'(busy_o), 64'd1);
    tick();
    check("tmo_err", 64'(m_err_o), 64'd1);
    check("tmo_busy_fall", 64'(busy_o), 64'd0);
    tick();
    no_ack = 1'b0;

    // Illegal read+write from requester 1.
    s0 = strb;
    drive_req(1, 1'b1, 1'b1, 32'h3000, 64'd0, 8'hFF);
    push(1, 1'b1, 1'b0, 64'd0);
    tick();
    check("ill_no_strobe", 64'({s_wen_o, s_ren_o}), 64'd0);
    tick();
    check("ill_err", 64'(m_err_o), 64'd2);
    tick();
    check("ill_err_once", 64'(m_err_o), 64'd0);
    check("ill_idle", 64'(busy_o), 64'd0);
    check("ill_strobes", 64'(strb - s0), 64'd0);

    // Reset while waiting; the held request is re-arbitrated afterwards.
    no_ack = 1'b1;
    drive_req(1, 1'b1, 1'b0, 32'h2000, 64'hCAFE, 8'hFF);
    tick();
    tick();
    check("rstw_busy_before", 64'(busy_o), 64'd1);
    rstn = 1'b0;
    tick();
    check("rstw_busy", 64'(busy_o), 64'd0);
    check("rstw_ack_err", 64'({m_ack_o, m_err_o}), 64'd0);
    check("rstw_addr", 64'(s_addr_o), 64'd0);
    check("rstw_wdata", s_wdata_o, 64'd0);
    check("rstw_rdata", m_rdata_o, 64'd0);
    no_ack = 1'b0;
    rstn   = 1'b1;
    push(1, 1'b0, 1'b0, 64'd0);
    wait_idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sys_bus_arbiter.md
SYS_BUS_ARBITER -- requirements
Module: sys_bus_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing one sys-bus target (range 2..4).
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 64, data width.
REQ-004 Parameter SW, default 8, byte-select width (DW/8).
REQ-005 Parameter TMO, default 255, WAIT-state timeout in cycles (1..65535).
REQ-006 Port clk  in  1  clock; rstn  in  1  reset (synchronous, active-low; clock clk).
REQ-007 Port m_addr_i  in  NREQ*AW  per-requester address, requester k in slice k.
REQ-008 Port m_wdata_i  in  NREQ*DW  per-requester write data.
REQ-009 Port m_sel_i  in  NREQ*SW  per-requester byte selects.
REQ-010 Port m_wen_i / m_ren_i  in  NREQ each  per-requester write / read request levels.
REQ-011 Port m_rdata_o  out  DW  read data, shared and qualified by m_ack_o.
REQ-012 Port m_ack_o / m_err_o  out  NREQ each  per-requester completion / error pulses.
REQ-013 Port s_addr_o, s_wdata_o, s_sel_o  out  AW, DW, SW  target request fields.
REQ-014 Port s_wen_o / s_ren_o  out  1 each  target strobes.
REQ-015 Port s_rdata_i, s_ack_i, s_err_i  in  DW, 1, 1  target response.
REQ-016 Port busy_o  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 A requester asserts m_wen_i[k] or m_ren_i[k] and SHALL hold it and its fields stable until m_ack_o[k] or m_err_o[k] pulses.
REQ-018 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-019 IDLE: when any request is present, one requester is granted by round-robin, its fields are registered, and the FSM moves to ISSUE.
REQ-020 Round-robin: search starts at (last_grant+1) mod NREQ; last_grant resets to NREQ-1, so requester 0 wins the first contention.
REQ-021 ISSUE: the FSM drives s_wen_o or s_ren_o high for exactly one cycle with the registered fields, then moves to WAIT.
REQ-022 WAIT: s_addr_o, s_wdata_o and s_sel_o stay stable and both strobes stay low.
REQ-023 On s_ack_i=1 in WAIT, the FSM pulses m_ack_o[grant] for 1 cycle on the next cycle and returns to IDLE; for reads, m_rdata_o carries the s_rdata_i sampled with the ack.
REQ-024 On s_err_i=1 in WAIT, the FSM pulses m_err_o[grant] instead; s_err_i takes priority over s_ack_i when both are high.
REQ-025 A WAIT cycle counter (16 bits) clears on entry to WAIT; when it reaches TMO with no response, the FSM pulses m_err_o[grant] and returns to IDLE.
REQ-026 m_wen_i[k] and m_ren_i[k] both high is illegal: the request is granted, no target strobe is issued, m_err_o[k] pulses one cycle after ISSUE, and the FSM returns to IDLE.
REQ-027 Minimum latency: request seen in IDLE at cycle t, strobe at t+1, target ack at t+2, m_ack_o at t+3; back-to-back throughput is one transfer per 4 cycles.
REQ-028 A request arriving while the FSM is not in IDLE waits; no request is dropped or reordered within a requester.
REQ-029 m_rdata_o SHALL hold its last value when m_ack_o is low.
REQ-030 s_ack_i or s_err_i arriving outside WAIT SHALL be ignored.

Reset
REQ-031 While rstn=0 at a clk edge: FSM=IDLE, last_grant=NREQ-1, counter=0, and all outputs are 0.
REQ-032 Reset mid-transaction aborts it with no ack or err pulse; a request still held after reset is re-arbitrated.

Structure
REQ-033 State enum and a default timeout constant SHALL live in a shared package sys_bus_pkg.
REQ-034 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req vector, last_grant; outputs: one-hot grant, index).

Verification
REQ-035 Single read: requester 0 reads 0x1000 (memory holds 0xDEADBEEF12345678) -> s_ren_o pulses once, m_ack_o[0] pulses at t+3, m_rdata_o=0xDEADBEEF12345678.
REQ-036 Contention: requesters 0 and 1 request in the same cycle, repeated 4 times -> grants alternate 0,1,0,1, with no starvation.
REQ-037 Write with sel=0x0F, data=0x1122334455667788 to 0x2000, then read back -> readback low 32 bits =0x55667788, high bytes unchanged.
REQ-038 Timeout: target never acks with TMO=8 -> m_err_o[grant] pulses 8 cycles after WAIT entry, busy_o then falls.
REQ-039 Illegal request: m_wen_i[1] and m_ren_i[1] both high -> no s_wen_o/s_ren_o activity, m_err_o[1] pulses once.
REQ-040 Reset in WAIT -> all outputs 0 the next cycle, no ack or err pulse, FSM in IDLE.
